// File: rtl/align_stream_receiver.sv
// Consumer of the alignment buffer output stream: backpressures via clken, captures
// valid aligned words, checks address continuity and re-times words through a small FIFO.
module align_stream_receiver #(
  parameter int unsigned WIDTH      = 80,
  parameter int unsigned AWIDTH     = 9,
  parameter int unsigned BUF_DEPTH  = 512,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              clken,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [AWIDTH-1:0] in_addr,
  input  logic              in_rd_en,
  output logic [WIDTH-1:0]  out_data,
  output logic [AWIDTH-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              seq_err,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0]  mem_data [FIFO_DEPTH];
  logic [AWIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              clken_d;
  logic              exp_valid;
  logic [AWIDTH-1:0] exp_addr;

  logic              capture;
  logic              full;
  logic              wr;
  logic              drop;
  logic              pop;
  logic              mismatch;
  logic [AWIDTH-1:0] next_addr;

  // Capture/handshake decode; clken keeps two free slots for the word in flight upstream
  always_comb begin
    capture   = clken_d & ~in_rd_en;
    full      = (count == CW'(FIFO_DEPTH));
    wr        = capture & ~full;
    drop      = capture & full;
    out_valid = (count != '0);
    pop       = out_valid & out_ready;
    next_addr = (in_addr == AWIDTH'(BUF_DEPTH - 1)) ? '0 : in_addr + AWIDTH'(1);
    mismatch  = capture & exp_valid & (in_addr != exp_addr);
    clken     = ~rst & en & (count <= CW'(FIFO_DEPTH - 2));
    out_data  = out_valid ? mem_data[rd_ptr] : '0;
    out_addr  = out_valid ? mem_addr[rd_ptr] : '0;
  end

  // FIFO storage carries no reset; emptiness is tracked by count
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data[wr_ptr] <= in_data;
      mem_addr[wr_ptr] <= in_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      clken_d <= 1'b0;
    end else begin
      clken_d <= clken;
      if (wr)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Address continuity tracking; resynchronises on every capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_valid <= 1'b0;
      exp_addr  <= '0;
      seq_err   <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (clken_d && in_rd_en) begin
        exp_valid <= 1'b0;
      end else if (capture) begin
        exp_valid <= 1'b1;
        exp_addr  <= next_addr;
      end
      if (mismatch || drop)
        seq_err <= 1'b1;
      else if (clr_err)
        seq_err <= 1'b0;
      if (wr)
        word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/align_stream_receiver.md
Name: align_stream_receiver

Overview:
- Consumer end of the disparity alignment buffer's output stream.
- Drives the buffer's clock-enable as a backpressure signal and captures aligned words flagged by the buffer's active-low read-valid.
- Checks that the word addresses are contiguous and wrap correctly, then re-times the words into a small FIFO with a valid/ready handshake toward the post-processing window logic.

Parameters:
- WIDTH, 80, data word width (matches the alignment buffer).
- AWIDTH, 9, read-address tag width.
- BUF_DEPTH, 512, alignment buffer depth; address tags wrap from BUF_DEPTH-1 to 0.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 4.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global run enable; 0 freezes upstream via clken.
- clken  out  1  clock-enable to the alignment buffer; 1 lets it advance one step.
- in_data  in  WIDTH  aligned word from the buffer output register.
- in_addr  in  AWIDTH  address tag of in_data.
- in_rd_en  in  1  active-low: 0 means in_data/in_addr are a valid aligned word.
- out_data  out  WIDTH  FIFO head data.
- out_addr  out  AWIDTH  FIFO head address tag.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts the head when out_valid and out_ready are both 1.
- seq_err  out  1  sticky flag: address discontinuity detected.
- clr_err  in  1  synchronous clear of seq_err.
- word_cnt  out  CNT_W  number of words accepted into the FIFO; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1, asynchronous) forces:
  - clken=0, out_valid=0, out_data=0, out_addr=0, seq_err=0, word_cnt=0.
  - FIFO pointers and count to 0; clken_d=0; exp_valid=0.
- Backpressure:
  - clken = en AND (FIFO_DEPTH - count >= 2), combinational from registered count and en.
  - The 2-slot margin covers the one word in flight from the upstream output register.
- Capture timing:
  - The upstream buffer updates its outputs on an edge where clken=1, so a new word is presented in the following cycle.
  - clken_d is clken registered.
  - A capture occurs in a cycle where clken_d=1 AND in_rd_en=0. The word is written to the FIFO tail at that cycle's rising edge.
  - Cycles with clken_d=0 never capture, even if in_rd_en=0; the stale word is not duplicated.
- FIFO:
  - One-cycle latency: a word captured at edge N is visible on out_* after edge N with out_valid=1.
  - out_* show the head combinationally from storage and hold stable while out_valid=1 and out_ready=0.
  - Simultaneous capture and pop in the same cycle: count unchanged, both pointers advance.
  - Pop when empty: ignored.
  - The margin rule guarantees a capture never finds the FIFO full. If it would, the word is dropped and seq_err is set (defensive).
- Sequence check:
  - exp_valid=0 after reset and whenever a cycle has clken_d=1 AND in_rd_en=1 (upstream not yet streaming).
  - First capture with exp_valid=0: load exp_addr = in_addr+1, wrapping BUF_DEPTH-1 to 0, and set exp_valid=1.
  - Subsequent captures: if in_addr != exp_addr, set seq_err. Either way, exp_addr = in_addr+1 (wrapped); the check resynchronizes.
  - clr_err=1 clears seq_err. If a mismatch occurs in the same cycle as clr_err, seq_err ends at 1 (set wins).
- word_cnt increments by 1 per FIFO write; a dropped word does not increment it.
- en=0 mid-stream:
  - clken drops immediately.
  - One trailing word may still be captured (clken_d=1), then capture stops.
  - The FIFO keeps draining.
- Reset mid-operation: all state cleared and FIFO contents discarded. The upstream buffer is reset separately.

Test Plan:
1. Reset, then en=1, out_ready=1, upstream in_rd_en=1 for 10 advances then 0 with addresses 0,1,2,… -> out_addr sequence 0,1,2,… one cycle after each capture; seq_err=0; word_cnt=20 after 20 captures.
2. Wrap: stream addresses 509,510,511,0,1 -> all five output in order, seq_err stays 0.
3. Backpressure: out_ready=0 with continuous stream -> clken drops when count reaches FIFO_DEPTH-1=3; at most 4 words stored; no loss. Then out_ready=1 -> all words output in order and clken returns to 1.
4. Stall without duplication: en toggled 1,0,0,1 while in_rd_en=0 with in_addr held -> exactly one capture per clken_d=1 cycle; word_cnt matches the number of clken pulses.
5. Discontinuity: addresses 5,6,8,9 -> seq_err=1 after the capture of 8, no error on 9 (resync). clr_err pulse -> seq_err=0. A mismatch in the same cycle as clr_err -> seq_err=1.
6. Async reset asserted mid-stream with 3 words in the FIFO -> out_valid=0, clken=0, word_cnt=0 immediately, without waiting for a clock edge.
